// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared frame-FSM states, default port addresses and status bit
//            positions for the PS/2 receive front end.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] c_PORT_DATA_DEF   = 8'h02;
    localparam logic [7:0] c_PORT_STATUS_DEF = 8'h03;

    localparam int c_STAT_READY = 0;
    localparam int c_STAT_OVF   = 1;
    localparam int c_STAT_ERR   = 2;

endpackage

`default_nettype wire

// File: rtl/ps2_rx_fifo_line_cond.sv
// ============================================================================
// Module   : ps2_line_cond
// Purpose  : Synchronises both raw PS/2 lines, filters the clock line and
//            emits a one-cycle pulse on each filtered clock falling edge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_line_cond #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_raw,
    input  logic ps2_data_raw,
    output logic data_sync,
    output logic fall
);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_filt;
    logic                  r_filt_d;

    // Lines idle high, so every stage resets to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_hist      <= '1;
            r_filt      <= 1'b1;
            r_filt_d    <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_raw};
            r_data_sync <= {r_data_sync[0], ps2_data_raw};
            r_hist      <= {r_hist[FILTER_LEN-2:0], r_clk_sync[1]};
            if (&r_hist) begin
                r_filt <= 1'b1;
            end else if (~|r_hist) begin
                r_filt <= 1'b0;
            end
            r_filt_d    <= r_filt;
        end
    end

    assign data_sync = r_data_sync[1];
    assign fall      = r_filt_d & ~r_filt;

endmodule

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host deframer with scan-code FIFO and PicoBlaze
//            port read interface. Define PS2_PARITY_CHECK_EN to reject frames
//            with bad odd parity.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT_CYC = 20000,
    parameter logic [7:0] PORT_DATA   = c_PORT_DATA_DEF,
    parameter logic [7:0] PORT_STATUS = c_PORT_STATUS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_Clock,
    input  logic       PS2_Data,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] out_data,
    output logic       rx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] c_FULL     = CW'(DEPTH);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic            w_data_sync;
    logic            w_fall;

    ps2_state_e      r_state;
    ps2_state_e      w_state_next;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_push_pend;
    logic [7:0]      r_push_byte;
    logic            w_frame_done;
    logic            w_frame_err;
    logic            w_timeout;
    logic            w_parity_ok;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic            r_err;
    logic [7:0]      r_out_data;

    logic            w_ready;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_err_set;
    logic            w_stat_rd;
    logic [7:0]      w_status;
    logic [7:0]      w_rd_mux;

    ps2_line_cond #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_cond (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_raw  (PS2_Clock),
        .ps2_data_raw (PS2_Data),
        .data_sync    (w_data_sync),
        .fall         (w_fall)
    );

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    // ---------------- frame FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        w_frame_err  = 1'b0;
        w_timeout    = 1'b0;
        if (w_fall) begin
            case (r_state)
                IDLE:    if (!w_data_sync) w_state_next = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_state_next = PARITY;
                PARITY:  w_state_next = STOP;
                STOP: begin
                    w_state_next = IDLE;
                    if (w_data_sync && w_parity_ok) begin
                        w_frame_done = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end else if ((r_state != IDLE) && (r_tmo_cnt == c_TMO_LAST)) begin
            w_state_next = IDLE;
            w_timeout    = 1'b1;
        end
    end

    // The completed byte is staged one cycle before entering the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tmo_cnt   <= '0;
            r_push_pend <= 1'b0;
            r_push_byte <= '0;
`ifdef PS2_PARITY_CHECK_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_push_pend <= w_frame_done;
            if (w_frame_done) begin
                r_push_byte <= r_shift;
            end
            if (w_fall || (r_state == IDLE)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    IDLE: r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {w_data_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_parity <= w_data_sync;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- FIFO and read port ----------------
    assign w_ready   = (r_count != '0);
    assign w_full    = (r_count == c_FULL);
    assign w_pop     = read_strobe && (port_id == PORT_DATA) && w_ready;
    assign w_push    = r_push_pend && (!w_full || w_pop);
    assign w_ovf_set = r_push_pend && w_full && !w_pop;
    assign w_err_set = w_frame_err || w_timeout;
    assign w_stat_rd = read_strobe && (port_id == PORT_STATUS);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_push_byte;
        end
    end

    always_comb begin
        w_status               = 8'h00;
        w_status[c_STAT_READY] = w_ready;
        w_status[c_STAT_OVF]   = r_ovf;
        w_status[c_STAT_ERR]   = r_err;
        if (port_id == PORT_DATA) begin
            w_rd_mux = w_ready ? r_mem[r_rd_ptr] : 8'h00;
        end else if (port_id == PORT_STATUS) begin
            w_rd_mux = w_status;
        end else begin
            w_rd_mux = 8'h00;
        end
    end

    // Sticky flags: a set event in the same cycle as a status read wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_out_data <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            r_ovf      <= w_ovf_set || (r_ovf && !w_stat_rd);
            r_err      <= w_err_set || (r_err && !w_stat_rd);
            r_out_data <= w_rd_mux;
        end
    end

    assign out_data = r_out_data;
    assign rx_ready = w_ready;

endmodule

`default_nettype wire
